alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the 8-bit combinational ALU. Latches operands on
//  accept, executes single-cycle ops (ADD/SUB/ADC/EQU/GTR/AND/XOR) and iterative
//  multi-cycle ops (SLL/SRL at 1 bit/cycle, MUL by shift-add), and holds the result plus
//  zero/carry flags until the consumer takes it. Sits between reg file/accumulator and writeback.
// PARAMETERS
//  WIDTH   8   operand/result width in bits, >= 2
//  CNT_W   $clog2(WIDTH+1)   iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      block can accept a request this cycle
//  op_ctrl    in   4      0 ADD,1 SUB,2 SLL,3 SRL,4 EQU,5 GTR,6 AND,7 XOR,8 MUL,9 ADC,10-15 reserved
//  reg_in     in   WIDTH  register-file operand (A)
//  acc_in     in   WIDTH  accumulator operand (B)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result this cycle
//  rslt_out   out  WIDTH  result
//  zero_out   out  1      rslt_out == 0
//  carry_out  out  1      carry/borrow/overflow of the delivered op (see below)
//  busy       out  1      high in BUSY state
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, out_valid=0, rslt_out=0, zero_out=0, carry_out=0,
//    carry flag reg=0, counter=0; in-flight op discarded. in_ready=1 after release.
//  - FSM IDLE->(accept)->DONE for single-cycle ops and shift amount 0; IDLE->BUSY for
//    SLL/SRL with A!=0 and for MUL; BUSY->DONE when counter hits 0; DONE->IDLE on out_ready.
//  - Accept = in_valid && in_ready; in_ready = (IDLE) || (DONE && out_ready). Accept in DONE
//    with out_ready enters DONE/BUSY directly (back-to-back, no bubble).
//  - Operands and op latched on accept; inputs ignored otherwise.
//  - Latency (accept edge to out_valid high): 1 cycle single-cycle ops; SLL/SRL 1+min(A,WIDTH);
//    MUL WIDTH+1. In DONE, rslt_out/zero_out/carry_out stay stable until out_ready.
//  - ADD: B+A mod 2^WIDTH, carry=carry-out. SUB: A-B, carry=borrow (A<B). ADC: A+B+Cflag.
//  - SLL/SRL: B shifted by A logically, zero-fill; A>=WIDTH -> result 0 after WIDTH steps;
//    carry=last bit shifted out (0 if A=0).
//  - MUL: unsigned A*B, rslt_out=low WIDTH bits, carry=1 iff high WIDTH bits nonzero.
//  - EQU: (A==B) zero-extended; GTR: unsigned A>B zero-extended; AND/XOR bitwise; carry=0.
//  - Reserved op: result 0, zero_out=1, carry=0, latency 1; never hangs.
//  - Carry flag reg (ADC input) updated only when ADD/SUB/ADC/MUL result is delivered
//    (DONE && out_ready); other ops leave it unchanged.
//  - zero_out reflects final rslt_out of every op, including SUB (result is the difference).
// TESTING (WIDTH=8)
//  - ADD A=0xF0,B=0x20 -> rslt 0x10, carry 1, zero 0, out_valid 1 cycle after accept.
//  - SUB A=0x33,B=0x33 -> 0x00, zero 1, carry 0; SUB A=0x01,B=0x02 -> 0xFF, carry 1.
//  - SLL B=0x81,A=3 -> 0x08, carry 0, latency 4; SRL B=0x81,A=9 -> 0x00, latency 9, busy high 8 cycles.
//  - MUL 0x0F*0x11 -> 0xFF, carry 0; MUL 0x10*0x10 -> 0x00, zero 1, carry 1, latency 9;
//    then ADC A=0,B=0 -> 0x01.
//  - Hold out_ready=0 5 cycles in DONE -> outputs stable, in_ready 0; raise out_ready with
//    in_valid -> next op accepted same edge.
//  - Assert rst_n=0 mid-MUL (cycle 4) -> out_valid 0, busy 0, flags 0 immediately; in_ready 1 after release.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic ops plus iterative shifts
// (1 bit/cycle) and shift-add multiply; result and flags held until consumed.
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_ctrl,
  input  logic [WIDTH-1:0] reg_in,
  input  logic [WIDTH-1:0] acc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt_out,
  output logic             zero_out,
  output logic             carry_out,
  output logic             busy
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SRL = 4'd3,
                         OP_EQU = 4'd4, OP_GTR = 4'd5, OP_AND = 4'd6, OP_XOR = 4'd7,
                         OP_MUL = 4'd8, OP_ADC = 4'd9;
  localparam logic [WIDTH-1:0] W_LIM = WIDTH[WIDTH-1:0];
  localparam logic [CNT_W-1:0] W_CNT = WIDTH[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   opr_a;
  logic [2*WIDTH-1:0] work;
  logic [CNT_W-1:0]   cnt;
  logic               cflag;

  logic accept, deliver, cf_eff, is_iter;
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] step;
  logic             step_c;

  function automatic logic upd_cf(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_MUL);
  endfunction

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign deliver  = (state == DONE) && out_ready;
  // An ADC accepted on the delivery edge must see the carry being delivered.
  assign cf_eff   = (deliver && upd_cf(op_q)) ? carry_out : cflag;

  assign is_iter  = (op_ctrl == OP_MUL) ||
                    ((op_ctrl == OP_SLL || op_ctrl == OP_SRL) && reg_in != '0);
  assign cnt_init = (op_ctrl == OP_MUL || reg_in >= W_LIM) ? W_CNT : reg_in[CNT_W-1:0];

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sum    = '0;
    case (op_ctrl)
      OP_ADD: begin sum = {1'b0, acc_in} + {1'b0, reg_in}; sc_res = sum[WIDTH-1:0]; sc_c = sum[WIDTH]; end
      OP_SUB: begin sum = {1'b0, reg_in} - {1'b0, acc_in}; sc_res = sum[WIDTH-1:0]; sc_c = sum[WIDTH]; end
      OP_ADC: begin
        sum = {1'b0, reg_in} + {1'b0, acc_in} + {{WIDTH{1'b0}}, cf_eff};
        sc_res = sum[WIDTH-1:0];
        sc_c = sum[WIDTH];
      end
      OP_SLL, OP_SRL: sc_res = acc_in;
      OP_EQU: sc_res = {{(WIDTH-1){1'b0}}, reg_in == acc_in};
      OP_GTR: sc_res = {{(WIDTH-1){1'b0}}, reg_in > acc_in};
      OP_AND: sc_res = reg_in & acc_in;
      OP_XOR: sc_res = reg_in ^ acc_in;
      default: sc_res = '0;
    endcase
  end

  // Shift-add multiply: multiplier in work low half, partial product enters from the top.
  assign mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opr_a} : '0);

  always_comb begin
    step   = work;
    step_c = 1'b0;
    case (op_q)
      OP_SLL: begin step = {{WIDTH{1'b0}}, work[WIDTH-2:0], 1'b0}; step_c = work[WIDTH-1]; end
      OP_SRL: begin step = {{WIDTH{1'b0}}, 1'b0, work[WIDTH-1:1]}; step_c = work[0]; end
      default: begin step = {mul_sum, work[WIDTH-1:1]}; step_c = |mul_sum[WIDTH:1]; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      opr_a     <= '0;
      work      <= '0;
      cnt       <= '0;
      cflag     <= 1'b0;
      out_valid <= 1'b0;
      rslt_out  <= '0;
      zero_out  <= 1'b0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (deliver && upd_cf(op_q)) cflag <= carry_out;
      if (accept) begin
        op_q  <= op_ctrl;
        opr_a <= reg_in;
        work  <= {{WIDTH{1'b0}}, acc_in};
        cnt   <= is_iter ? cnt_init : '0;
        if (is_iter) begin
          state     <= BUSY;
          busy      <= 1'b1;
          out_valid <= 1'b0;
        end else begin
          state     <= DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
          rslt_out  <= sc_res;
          zero_out  <= (sc_res == '0);
          carry_out <= sc_c;
        end
      end else begin
        case (state)
          BUSY: begin
            work <= step;
            cnt  <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state     <= DONE;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              rslt_out  <= step[WIDTH-1:0];
              zero_out  <= (step[WIDTH-1:0] == '0);
              carry_out <= step_c;
            end
          end
          DONE: if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): per-feature tasks with hand-computed expectations.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op_ctrl = '0;
  logic [7:0] reg_in = '0, acc_in = '0;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] rslt_out;
  logic       zero_out, carry_out, busy;
  int checks = 0, errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_ctrl(op_ctrl), .reg_in(reg_in), .acc_in(acc_in), .out_valid(out_valid),
    .out_ready(out_ready), .rslt_out(rslt_out), .zero_out(zero_out),
    .carry_out(carry_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op from IDLE and wait for out_valid; lat=-1 on timeout.
  task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     output int lat, output int bcnt);
    op_ctrl = op; reg_in = a; acc_in = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; lat = 1; bcnt = 0;
    while (!out_valid && lat < 40) begin
      bcnt += int'(busy);
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic take();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (rslt_out !== 8'h00) begin errors++; $display("FAIL rst_rslt got %h exp 00", rslt_out); end
    checks++; if ({zero_out, carry_out, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {zero_out, carry_out, busy}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    int lat, bc;
    run(4'd0, 8'hF0, 8'h20, lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat got %0d exp 1", lat); end
    checks++; if ({rslt_out, carry_out, zero_out} !== {8'h10, 1'b1, 1'b0}) begin errors++; $display("FAIL add got %h c%b z%b exp 10 c1 z0", rslt_out, carry_out, zero_out); end
    take();
  endtask

  task automatic test_sub();
    int lat, bc;
    run(4'd1, 8'h33, 8'h33, lat, bc);
    checks++; if ({rslt_out, zero_out, carry_out} !== {8'h00, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_eq got %h z%b c%b exp 00 z1 c0", rslt_out, zero_out, carry_out); end
    take();
    run(4'd1, 8'h01, 8'h02, lat, bc);
    checks++; if ({rslt_out, zero_out, carry_out} !== {8'hFF, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_borrow got %h z%b c%b exp ff z0 c1", rslt_out, zero_out, carry_out); end
    take();
  endtask

  task automatic test_logic();
    logic [3:0] ops [6] = '{4'd6, 4'd7, 4'd4, 4'd5, 4'd5, 4'd12};
    logic [7:0] as  [6] = '{8'hF0, 8'hF0, 8'h05, 8'h03, 8'h05, 8'hAA};
    logic [7:0] bs  [6] = '{8'h3C, 8'h3C, 8'h05, 8'h05, 8'h03, 8'h55};
    logic [7:0] ex  [6] = '{8'h30, 8'hCC, 8'h01, 8'h00, 8'h01, 8'h00};
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      run(ops[i], as[i], bs[i], lat, bc);
      checks++;
      if (lat !== 1 || rslt_out !== ex[i] || carry_out !== 1'b0 || zero_out !== (ex[i] == 8'h00)) begin
        errors++; $display("FAIL logic_%0d got %h c%b z%b lat %0d exp %h c0 lat 1", i, rslt_out, carry_out, zero_out, lat, ex[i]);
      end
      take();
    end
  endtask

  task automatic test_shift();
    int lat, bc;
    run(4'd2, 8'd3, 8'h81, lat, bc);
    checks++; if ({rslt_out, carry_out} !== {8'h08, 1'b0} || lat !== 4) begin errors++; $display("FAIL sll got %h c%b lat %0d exp 08 c0 lat 4", rslt_out, carry_out, lat); end
    take();
    run(4'd3, 8'd9, 8'h81, lat, bc);
    checks++; if ({rslt_out, carry_out, zero_out} !== {8'h00, 1'b1, 1'b1} || lat !== 9) begin errors++; $display("FAIL srl9 got %h c%b z%b lat %0d exp 00 c1 z1 lat 9", rslt_out, carry_out, zero_out, lat); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL srl9_busy got %0d exp 8", bc); end
    take();
    run(4'd2, 8'd0, 8'h5A, lat, bc);
    checks++; if ({rslt_out, carry_out} !== {8'h5A, 1'b0} || lat !== 1) begin errors++; $display("FAIL sll0 got %h c%b lat %0d exp 5a c0 lat 1", rslt_out, carry_out, lat); end
    take();
  endtask

  task automatic test_mul();
    int lat, bc;
    run(4'd8, 8'h0F, 8'h11, lat, bc);
    checks++; if ({rslt_out, carry_out} !== {8'hFF, 1'b0} || lat !== 9) begin errors++; $display("FAIL mul_ff got %h c%b lat %0d exp ff c0 lat 9", rslt_out, carry_out, lat); end
    take();
    run(4'd8, 8'h0C, 8'h0B, lat, bc);
    checks++; if ({rslt_out, carry_out} !== {8'h84, 1'b0}) begin errors++; $display("FAIL mul_84 got %h c%b exp 84 c0", rslt_out, carry_out); end
    take();
    run(4'd8, 8'h10, 8'h10, lat, bc);
    checks++; if ({rslt_out, zero_out, carry_out} !== {8'h00, 1'b1, 1'b1} || lat !== 9) begin errors++; $display("FAIL mul_ovf got %h z%b c%b lat %0d exp 00 z1 c1 lat 9", rslt_out, zero_out, carry_out, lat); end
    take();
    run(4'd9, 8'h00, 8'h00, lat, bc);
    checks++; if ({rslt_out, carry_out} !== {8'h01, 1'b0}) begin errors++; $display("FAIL adc got %h c%b exp 01 c0", rslt_out, carry_out); end
    take();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run(4'd0, 8'h01, 8'h02, lat, bc);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, rslt_out, zero_out, carry_out, in_ready} !== {1'b1, 8'h03, 1'b0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL hold_%0d got v%b %h z%b c%b rdy%b exp v1 03 z0 c0 rdy0", i, out_valid, rslt_out, zero_out, carry_out, in_ready);
      end
      tick();
    end
    op_ctrl = 4'd7; reg_in = 8'hFF; acc_in = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if ({out_valid, rslt_out} !== {1'b1, 8'hF0}) begin errors++; $display("FAIL b2b got v%b %h exp v1 f0", out_valid, rslt_out); end
    take();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    op_ctrl = 4'd8; reg_in = 8'hFF; acc_in = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    rst_n = 1'b0; #1;
    checks++; if ({out_valid, busy, zero_out, carry_out} !== 4'b0000) begin errors++; $display("FAIL mid_rst got %b exp 0000", {out_valid, busy, zero_out, carry_out}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin errors++; $display("FAIL post_rst got %b exp 100", {in_ready, out_valid, busy}); end
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
